// File: rtl/level_pkg.sv
// Shared constants, ROM word layout, FSM state type and grid coordinate type for level_loader.
package level_pkg;

   localparam int unsigned LEVEL_STRIDE    = 16;
   localparam int unsigned WORDS_PER_LEVEL = 8;
   localparam int unsigned MAX_COINS       = 6;
   localparam logic [4:0]  PARK_POS        = 5'd31;

   // ROM word field positions and word indices within a level record
   localparam int unsigned X_MSB      = 9;
   localparam int unsigned X_LSB      = 5;
   localparam int unsigned Y_MSB      = 4;
   localparam int unsigned Y_LSB      = 0;
   localparam int unsigned CNT_MSB    = 2;
   localparam int unsigned CNT_LSB    = 0;
   localparam int unsigned HDR_IDX    = 0;
   localparam int unsigned PLAYER_IDX = 1;
   localparam int unsigned COIN0_IDX  = 2;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StFetch  = 2'd1,
      StCommit = 2'd2,
      StDone   = 2'd3
   } state_e;

   typedef struct packed {
      logic [4:0] x;
      logic [4:0] y;
   } grid_pos_t;

   function automatic logic [2:0] clamp_count(input logic [2:0] hdr_cnt);
      return (hdr_cnt > 3'(MAX_COINS)) ? 3'(MAX_COINS) : hdr_cnt;
   endfunction

endpackage

// File: rtl/level_shadow_regs.sv
// Eight-entry capture registers for one level record, plus the committed positions that
// are bulk-loaded from them in a single edge (unused coins parked off-grid).
module level_shadow_regs
   import level_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        wr_en_i,
   input  logic [2:0]                  wr_idx_i,
   input  logic [9:0]                  wr_data_i,
   input  logic                        commit_i,
   input  logic [2:0]                  coin_count_i,
   output logic [2:0]                  hdr_cnt_o,
   output grid_pos_t                   player_o,
   output grid_pos_t [MAX_COINS-1:0]   coins_o
);

   logic [9:0]                shadow_q [WORDS_PER_LEVEL];
   grid_pos_t                 player_q;
   grid_pos_t [MAX_COINS-1:0] coins_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < WORDS_PER_LEVEL; i++) shadow_q[i] <= '0;
         player_q <= '0;
         coins_q  <= '0;
      end else begin
         if (wr_en_i) shadow_q[wr_idx_i] <= wr_data_i;
         if (commit_i) begin
            player_q <= grid_pos_t'(shadow_q[PLAYER_IDX]);
            for (int i = 0; i < MAX_COINS; i++) begin
               coins_q[i] <= (3'(i) < coin_count_i) ? grid_pos_t'(shadow_q[COIN0_IDX + i])
                                                    : '{x: PARK_POS, y: PARK_POS};
            end
         end
      end
   end

   assign hdr_cnt_o = shadow_q[HDR_IDX][CNT_MSB:CNT_LSB];
   assign player_o  = player_q;
   assign coins_o   = coins_q;

endmodule

// File: rtl/level_loader.sv
// Fetches one level record from a synchronous ROM and commits player/coin start positions.
// Optional macro LEVEL_CHECKSUM_EN adds an XOR checksum word that gates the commit.
module level_loader
   import level_pkg::*;
#(
   parameter int unsigned NUM_LEVELS = 8,
   parameter int unsigned ROM_AW     = 7,
   parameter int unsigned LVL_W      = 3
) (
   input  logic              Clk,
   input  logic              RESET,
   input  logic              load_req,
   input  logic [LVL_W-1:0]  level_num,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [9:0]        rom_data,
   output logic              busy,
   output logic              initialize_level,
   output logic              load_err,
   output logic [2:0]        coin_count,
   output logic [4:0]        Player_start_X,
   output logic [4:0]        Player_start_y,
   output logic [4:0]        Coin0_startx,
   output logic [4:0]        Coin0_starty,
   output logic [4:0]        Coin1_startx,
   output logic [4:0]        Coin1_starty,
   output logic [4:0]        Coin2_startx,
   output logic [4:0]        Coin2_starty,
   output logic [4:0]        Coin3_startx,
   output logic [4:0]        Coin3_starty,
   output logic [4:0]        Coin4_startx,
   output logic [4:0]        Coin4_starty,
   output logic [4:0]        Coin5_startx,
   output logic [4:0]        Coin5_starty
);

`ifdef LEVEL_CHECKSUM_EN
   localparam logic [3:0] LastWord = 4'd8;
`else
   localparam logic [3:0] LastWord = 4'd7;
`endif

   state_e            state_q, state_d;
   logic [3:0]        fcnt_q, fcnt_d;
   logic [ROM_AW-1:0] addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              init_q, init_d;
   logic              err_q, err_d;
   logic [2:0]        count_q, count_d;
   logic              wr_en, commit;
   logic [2:0]        wr_idx, hdr_cnt;
   logic [ROM_AW-1:0] base;
   grid_pos_t                 player;
   grid_pos_t [MAX_COINS-1:0] coins;
`ifdef LEVEL_CHECKSUM_EN
   logic [9:0]        xor_q, xor_d, sum_q, sum_d;
`endif

   assign base   = ROM_AW'(32'(level_num) * LEVEL_STRIDE);
   assign wr_idx = 3'(fcnt_q - 4'd1);

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      addr_d  = addr_q;
      busy_d  = busy_q;
      init_d  = 1'b0;
      err_d   = err_q;
      count_d = count_q;
      wr_en   = 1'b0;
      commit  = 1'b0;
`ifdef LEVEL_CHECKSUM_EN
      xor_d   = xor_q;
      sum_d   = sum_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (load_req) begin
               if (32'(level_num) < NUM_LEVELS) begin
                  addr_d  = base;
                  busy_d  = 1'b1;
                  err_d   = 1'b0;
                  fcnt_d  = '0;
                  state_d = StFetch;
`ifdef LEVEL_CHECKSUM_EN
                  xor_d   = '0;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StFetch: begin
            // fcnt_q counts edges since the base address; data for word n lands at fcnt_q=n+1
            fcnt_d = fcnt_q + 4'd1;
            if (fcnt_q < LastWord) addr_d = addr_q + 1'b1;
            if (fcnt_q != 4'd0 && fcnt_q <= 4'(WORDS_PER_LEVEL)) begin
               wr_en = 1'b1;
`ifdef LEVEL_CHECKSUM_EN
               xor_d = xor_q ^ rom_data;
`endif
            end
`ifdef LEVEL_CHECKSUM_EN
            if (fcnt_q == 4'(WORDS_PER_LEVEL + 1)) sum_d = rom_data;
`endif
            if (fcnt_q == LastWord + 4'd1) state_d = StCommit;
         end
         StCommit: begin
            commit  = 1'b1;
            count_d = clamp_count(hdr_cnt);
            if (hdr_cnt > 3'(MAX_COINS)) err_d = 1'b1;
            init_d  = 1'b1;
            state_d = StDone;
`ifdef LEVEL_CHECKSUM_EN
            if (xor_q != sum_q) begin
               commit  = 1'b0;
               count_d = count_q;
               err_d   = 1'b1;
               init_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
`endif
         end
         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!RESET) begin
         state_q <= StIdle;
         fcnt_q  <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         init_q  <= 1'b0;
         err_q   <= 1'b0;
         count_q <= '0;
`ifdef LEVEL_CHECKSUM_EN
         xor_q   <= '0;
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         init_q  <= init_d;
         err_q   <= err_d;
         count_q <= count_d;
`ifdef LEVEL_CHECKSUM_EN
         xor_q   <= xor_d;
         sum_q   <= sum_d;
`endif
      end
   end

   level_shadow_regs u_shadow (
      .clk_i        (Clk),
      .rst_ni       (RESET),
      .wr_en_i      (wr_en),
      .wr_idx_i     (wr_idx),
      .wr_data_i    (rom_data),
      .commit_i     (commit),
      .coin_count_i (clamp_count(hdr_cnt)),
      .hdr_cnt_o    (hdr_cnt),
      .player_o     (player),
      .coins_o      (coins)
   );

   assign rom_addr         = addr_q;
   assign busy             = busy_q;
   assign initialize_level = init_q;
   assign load_err         = err_q;
   assign coin_count       = count_q;
   assign Player_start_X   = player.x;
   assign Player_start_y   = player.y;
   assign Coin0_startx     = coins[0].x;
   assign Coin0_starty     = coins[0].y;
   assign Coin1_startx     = coins[1].x;
   assign Coin1_starty     = coins[1].y;
   assign Coin2_startx     = coins[2].x;
   assign Coin2_starty     = coins[2].y;
   assign Coin3_startx     = coins[3].x;
   assign Coin3_starty     = coins[3].y;
   assign Coin4_startx     = coins[4].x;
   assign Coin4_starty     = coins[4].y;
   assign Coin5_startx     = coins[5].x;
   assign Coin5_starty     = coins[5].y;

endmodule

// File: tb/tb_level_loader.sv
// Self-checking bench for level_loader: transaction-timeline reference model plus literal pins.
module tb_level_loader;

   localparam int NL = 8;
   localparam int AW = 7;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_req = 1'b0;
   logic [LW-1:0] level_num = '0;
   logic [AW-1:0] rom_addr;
   logic [9:0]    rom_data;
   logic          busy, init_lvl, load_err;
   logic [2:0]    coin_count;
   logic [4:0]    px, py;
   logic [4:0]    cx [6];
   logic [4:0]    cy [6];

   logic [9:0]    rom [128];

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   level_loader #(.NUM_LEVELS(NL), .ROM_AW(AW), .LVL_W(LW)) dut (
      .Clk              (clk),
      .RESET            (rst_n),
      .load_req         (load_req),
      .level_num        (level_num),
      .rom_addr         (rom_addr),
      .rom_data         (rom_data),
      .busy             (busy),
      .initialize_level (init_lvl),
      .load_err         (load_err),
      .coin_count       (coin_count),
      .Player_start_X   (px),
      .Player_start_y   (py),
      .Coin0_startx     (cx[0]),
      .Coin0_starty     (cy[0]),
      .Coin1_startx     (cx[1]),
      .Coin1_starty     (cy[1]),
      .Coin2_startx     (cx[2]),
      .Coin2_starty     (cy[2]),
      .Coin3_startx     (cx[3]),
      .Coin3_starty     (cy[3]),
      .Coin4_startx     (cx[4]),
      .Coin4_starty     (cy[4]),
      .Coin5_startx     (cx[5]),
      .Coin5_starty     (cy[5])
   );

   // Reference model: a load accepted at edge k is a timeline of edges k..k+11
   logic       m_active = 1'b0;
   int         m_t = 0;
   int         m_base = 0;
   logic [6:0] m_addr = '0;
   logic       m_busy = 1'b0, m_init = 1'b0, m_err = 1'b0;
   logic [2:0] m_cnt = '0;
   logic [9:0] m_player = '0;
   logic [9:0] m_coin [6];

   function automatic int count_of(input int b);
      int h;
      h = int'(rom[b][2:0]);
      return (h > 6) ? 6 : h;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_t      <= 0;
         m_addr   <= '0;
         m_busy   <= 1'b0;
         m_init   <= 1'b0;
         m_err    <= 1'b0;
         m_cnt    <= '0;
         m_player <= '0;
         for (int i = 0; i < 6; i++) m_coin[i] <= '0;
      end else if (m_active) begin
         m_t    <= m_t + 1;
         m_init <= (m_t + 1 == 10);
         if (m_t + 1 <= 7) m_addr <= 7'(m_base + m_t + 1);
         if (m_t + 1 == 10) begin
            m_cnt    <= 3'(count_of(m_base));
            m_player <= rom[m_base + 1];
            if (rom[m_base][2:0] == 3'd7) m_err <= 1'b1;
            for (int i = 0; i < 6; i++)
               m_coin[i] <= (i < count_of(m_base)) ? rom[m_base + 2 + i] : 10'h3ff;
         end
         if (m_t + 1 == 11) begin
            m_busy   <= 1'b0;
            m_active <= 1'b0;
         end
      end else begin
         m_init <= 1'b0;
         if (load_req) begin
            if (int'(level_num) < NL) begin
               m_active <= 1'b1;
               m_t      <= 0;
               m_base   <= int'(level_num) * 16;
               m_addr   <= 7'(int'(level_num) * 16);
               m_busy   <= 1'b1;
               m_err    <= 1'b0;
            end else begin
               m_err <= 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to the next falling edge and compare every output against the model
   task automatic tick();
      @(negedge clk);
      if (init_lvl === 1'b1) pulses++;
      check("busy", 32'(busy), 32'(m_busy));
      check("initialize_level", 32'(init_lvl), 32'(m_init));
      check("load_err", 32'(load_err), 32'(m_err));
      check("rom_addr", 32'(rom_addr), 32'(m_addr));
      check("coin_count", 32'(coin_count), 32'(m_cnt));
      check("player", 32'({px, py}), 32'(m_player));
      for (int i = 0; i < 6; i++) check("coin", 32'({cx[i], cy[i]}), 32'(m_coin[i]));
   endtask

   task automatic req(input int lvl);
      tick();
      load_req  = 1'b1;
      level_num = LW'(lvl);
      tick();
      load_req  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 30) begin
         tick();
         n++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   int p0;

   initial begin
      for (int a = 0; a < 128; a++) rom[a] = 10'($urandom_range(0, 1023));
      rom[32] = 10'd6;
      rom[33] = {5'd3, 5'd4};
      for (int i = 0; i < 6; i++) rom[34 + i] = {5'(i + 1), 5'(i + 1)};
      rom[48] = 10'd2;
      rom[49] = {5'd7, 5'd8};
      for (int i = 0; i < 6; i++) rom[50 + i] = {5'(10 + i), 5'(20 + i)};
      rom[64] = 10'd7;
      rom[65] = {5'd1, 5'd2};
      for (int i = 0; i < 6; i++) rom[66 + i] = {5'(i), 5'(30 - i)};

      @(posedge clk);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("reset_player", 32'(px), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);

      // Level 2: full six coins, pulse exactly after edge k+10
      req(2);
      check("lvl2_addr_k", 32'(rom_addr), 32'd32);
      repeat (10) tick();
      check("lvl2_pulse_k10", 32'(init_lvl), 32'd1);
      check("lvl2_addr_end", 32'(rom_addr), 32'd39);
      check("lvl2_px", 32'(px), 32'd3);
      check("lvl2_py", 32'(py), 32'd4);
      check("lvl2_coin5", 32'({cx[5], cy[5]}), 32'({5'd6, 5'd6}));
      check("lvl2_count", 32'(coin_count), 32'd6);
      wait_idle();

      // Level 3: two coins, rest parked
      req(3);
      wait_idle();
      check("lvl3_count", 32'(coin_count), 32'd2);
      check("lvl3_coin1", 32'({cx[1], cy[1]}), 32'({5'd11, 5'd21}));
      check("lvl3_coin2_park", 32'({cx[2], cy[2]}), 32'h3ff);
      check("lvl3_err", 32'(load_err), 32'd0);

      // Level 4: header 7 clamps to 6 and flags an error, still commits
      p0 = pulses;
      req(4);
      wait_idle();
      check("lvl4_count", 32'(coin_count), 32'd6);
      check("lvl4_err", 32'(load_err), 32'd1);
      check("lvl4_coin5", 32'({cx[5], cy[5]}), 32'({5'd5, 5'd25}));
      check("lvl4_pulses", 32'(pulses - p0), 32'd1);

      // Out-of-range level: error only, nothing else moves
      p0 = pulses;
      req(8);
      repeat (3) tick();
      check("bad_err", 32'(load_err), 32'd1);
      check("bad_addr", 32'(rom_addr), 32'd71);
      check("bad_px", 32'(px), 32'd1);
      check("bad_pulses", 32'(pulses - p0), 32'd0);
      req(2);
      check("recover_err", 32'(load_err), 32'd0);
      wait_idle();

      // Requests at k+3 and k+10 are ignored
      p0 = pulses;
      req(5);
      repeat (2) tick();
      load_req = 1'b1;
      level_num = 4'd3;
      tick();
      load_req = 1'b0;
      repeat (6) tick();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      repeat (3) tick();
      check("ignore_pulses", 32'(pulses - p0), 32'd1);
      check("ignore_busy", 32'(busy), 32'd0);

      // Reset mid-fetch
      p0 = pulses;
      req(6);
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      check("midrst_px", 32'(px), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_addr", 32'(rom_addr), 32'd0);
      rst_n = 1'b1;
      repeat (12) tick();
      check("midrst_pulses", 32'(pulses - p0), 32'd0);

      // Random traffic against the model
      for (int n = 0; n < 800; n++) begin
         load_req  = ($urandom_range(0, 5) == 0);
         level_num = LW'($urandom_range(0, 9));
         rst_n     = ($urandom_range(0, 200) != 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
